// File: rtl/rv32i_types.sv
// Shared RV32I encodings, control word and decode result types used by the
// decode stage and its combinational decoder.
package rv32i_types;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef struct packed {
        logic [6:0]     opcode;
        alu_ops         aluop;
        branch_funct3_t cmpop;
        logic           load_regfile;
        logic           mem_read;
        logic           mem_write;
        logic           br_sel;
    } rv32i_control_word;

    typedef struct packed {
        rv32i_control_word ctrl;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [31:0]       imm;
        logic              illegal;
    } decode_out_t;

    function automatic logic reads_rs1(logic [6:0] op);
        case (op)
            op_br, op_store, op_reg, op_jalr, op_load, op_imm: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(logic [6:0] op);
        case (op)
            op_br, op_store, op_reg: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational RV32I instruction decoder: control word, register
// fields, sign-extended immediate and illegal-opcode flag.
module control_decoder
    import rv32i_types::*;
(
    input  logic [31:0] instr,
    output decode_out_t dout
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        writes_rd;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign i_imm  = {{21{instr[31]}}, instr[30:20]};
    assign s_imm  = {{21{instr[31]}}, instr[30:25], instr[11:7]};
    assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm  = {instr[31:12], 12'h000};
    assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dout            = '0;
        writes_rd       = 1'b0;
        dout.rs1        = instr[19:15];
        dout.rs2        = instr[24:20];
        dout.rd         = instr[11:7];
        dout.ctrl.opcode = opcode;
        dout.ctrl.aluop = alu_ops'(funct3);
        dout.ctrl.cmpop = branch_funct3_t'(funct3);
        case (opcode)
            op_lui, op_auipc: begin
                dout.imm  = u_imm;
                writes_rd = 1'b1;
            end
            op_jal: begin
                dout.imm         = j_imm;
                writes_rd        = 1'b1;
                dout.ctrl.br_sel = 1'b1;
            end
            op_jalr: begin
                dout.imm         = i_imm;
                writes_rd        = 1'b1;
                dout.ctrl.br_sel = 1'b1;
            end
            op_br: begin
                dout.imm         = b_imm;
                dout.ctrl.br_sel = 1'b1;
            end
            op_load: begin
                dout.imm           = i_imm;
                writes_rd          = 1'b1;
                dout.ctrl.mem_read = 1'b1;
            end
            op_store: begin
                dout.imm            = s_imm;
                dout.ctrl.mem_write = 1'b1;
            end
            op_imm, op_reg: begin
                if (opcode == op_imm)
                    dout.imm = i_imm;
                writes_rd = 1'b1;
                // instr[30] selects sub/sra; set-less-than reuses the branch comparator
                case (funct3)
                    3'b000: if (opcode == op_reg && instr[30]) dout.ctrl.aluop = alu_sub;
                    3'b010: dout.ctrl.cmpop = blt;
                    3'b011: dout.ctrl.cmpop = bltu;
                    3'b101: dout.ctrl.aluop = instr[30] ? alu_sra : alu_srl;
                    default: ;
                endcase
            end
            op_csr: ;
            default: dout.illegal = 1'b1;
        endcase
        dout.ctrl.load_regfile = writes_rd && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one output register set with valid/ready handshakes,
// load-use bubble insertion and flush.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = rv32i_types::NOP_INSTR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           if_valid,
    output logic                           if_ready,
    input  logic [31:0]                    if_pc,
    input  logic [31:0]                    if_instr,
    output logic                           ex_valid,
    input  logic                           ex_ready,
    output logic [31:0]                    ex_pc,
    output logic [31:0]                    ex_instr,
    output rv32i_types::rv32i_control_word ex_ctrl,
    output logic [4:0]                     ex_rs1,
    output logic [4:0]                     ex_rs2,
    output logic [4:0]                     ex_rd,
    output logic [31:0]                    ex_imm,
    output logic                           ex_illegal,
    input  logic                           flush
);
    import rv32i_types::decode_out_t;
    import rv32i_types::reads_rs1;
    import rv32i_types::reads_rs2;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_BUBBLE} state_t;

    state_t      state;
    decode_out_t dec;
    logic        hazard;
    logic        in_xfer;

    control_decoder u_dec (
        .instr (if_instr),
        .dout  (dec)
    );

    // A held load whose destination feeds the incoming instruction cannot forward in time
    assign hazard = (state == ST_FULL) && ex_ctrl.mem_read && (ex_rd != 5'd0) && if_valid &&
                    ((reads_rs1(if_instr[6:0]) && (if_instr[19:15] == ex_rd)) ||
                     (reads_rs2(if_instr[6:0]) && (if_instr[24:20] == ex_rd)));

    assign if_ready = !rst && !flush && !hazard && ((state == ST_EMPTY) || ex_ready);
    assign in_xfer  = if_valid && if_ready;
    assign ex_valid = (state != ST_EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            ex_pc      <= 32'd0;
            ex_instr   <= NOP_INSTR;
            ex_ctrl    <= '0;
            ex_rs1     <= 5'd0;
            ex_rs2     <= 5'd0;
            ex_rd      <= 5'd0;
            ex_imm     <= 32'd0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (in_xfer) begin
            state      <= ST_FULL;
            ex_pc      <= if_pc;
            ex_instr   <= if_instr;
            ex_ctrl    <= dec.ctrl;
            ex_rs1     <= dec.rs1;
            ex_rs2     <= dec.rs2;
            ex_rd      <= dec.rd;
            ex_imm     <= dec.imm;
            ex_illegal <= dec.illegal;
        end else if (hazard && ex_ready) begin
            state      <= ST_BUBBLE;
            ex_instr   <= NOP_INSTR;
            ex_ctrl    <= '0;
            ex_illegal <= 1'b0;
        end else if (ex_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations followed
// by randomized traffic compared every cycle against a behavioural model.
module tb_decode_stage;
    import rv32i_types::*;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1, if_valid = 1'b0, ex_ready = 1'b0, flush = 1'b0;
    logic [31:0] if_pc = 32'd0, if_instr = 32'd0;
    logic if_ready, ex_valid, ex_illegal;
    logic [31:0] ex_pc, ex_instr, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    rv32i_control_word ex_ctrl;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_ctrl(ex_ctrl), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_illegal(ex_illegal),
        .flush(flush)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic is_legal(logic [6:0] op);
        return op inside {op_lui, op_auipc, op_jal, op_jalr, op_br, op_load,
                          op_store, op_imm, op_reg, op_csr};
    endfunction

    function automatic logic [31:0] ref_imm(logic [31:0] w);
        logic [31:0] i = 32'($signed(w) >>> 20);
        logic [31:0] s = (i & ~32'h1f) | {27'd0, w[11:7]};
        case (w[6:0])
            op_jalr, op_load, op_imm: return i;
            op_store: return s;
            op_br: return (s & ~32'h801) | {20'd0, w[7], 11'd0};
            op_lui, op_auipc: return w & 32'hFFFFF000;
            op_jal: return (i & 32'hFFF007FE) | (w & 32'h000FF000) | {20'd0, w[20], 11'd0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic rv32i_control_word ref_ctrl(logic [31:0] w);
        rv32i_control_word c;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        c = '0;
        c.opcode = op;
        c.aluop = alu_ops'(f3);
        c.cmpop = branch_funct3_t'(f3);
        if (op == op_imm || op == op_reg) begin
            if (f3 == 3'd5) c.aluop = w[30] ? alu_sra : alu_srl;
            if (f3 == 3'd0 && op == op_reg && w[30]) c.aluop = alu_sub;
            if (f3 == 3'd2) c.cmpop = blt;
            if (f3 == 3'd3) c.cmpop = bltu;
        end
        c.load_regfile = (op inside {op_lui, op_auipc, op_jal, op_jalr, op_load, op_imm, op_reg})
                         && (w[11:7] != 5'd0);
        c.mem_read  = (op == op_load);
        c.mem_write = (op == op_store);
        c.br_sel    = (op inside {op_br, op_jal, op_jalr});
        return c;
    endfunction

    function automatic logic src_hit(logic [31:0] w, logic [4:0] rd);
        logic [6:0] op = w[6:0];
        logic r1 = op inside {op_br, op_store, op_reg, op_jalr, op_load, op_imm};
        logic r2 = op inside {op_br, op_store, op_reg};
        return (r1 && w[19:15] == rd) || (r2 && w[24:20] == rd);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 13))
            0: w[6:0] = op_lui;
            1: w[6:0] = op_auipc;
            2: w[6:0] = op_jal;
            3: w[6:0] = op_jalr;
            4: w[6:0] = op_br;
            5, 6, 7: w[6:0] = op_load;
            8: w[6:0] = op_store;
            9, 10: w[6:0] = op_imm;
            11: w[6:0] = op_reg;
            12: w[6:0] = op_csr;
            default: w[6:0] = 7'b1111111;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // Behavioural model: what the stage holds (nothing, an instruction, or a bubble)
    logic        m_known = 1'b0, m_valid = 1'b0, m_bubble = 1'b0, m_acc = 1'b0;
    logic [31:0] m_pc = 32'd0, m_instr = 32'd0;

    always @(negedge clk) begin : model
        logic hz, er;
        rv32i_control_word c;
        hz = 1'b0;
        er = 1'b0;
        if (m_known) begin
            hz = m_valid && !m_bubble && (m_instr[6:0] == op_load) && (m_instr[11:7] != 5'd0)
                 && if_valid && src_hit(if_instr, m_instr[11:7]);
            er = !rst && !flush && !hz && (!m_valid || ex_ready);
            check("if_ready", {31'd0, if_ready}, {31'd0, er});
            check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            if (m_valid && m_bubble) begin
                check("bubble_ctrl", {15'd0, ex_ctrl}, 32'd0);
                check("bubble_instr", ex_instr, NOP);
            end else if (m_valid) begin
                c = ref_ctrl(m_instr);
                check("pc", ex_pc, m_pc);
                check("instr", ex_instr, m_instr);
                check("ctrl", {15'd0, ex_ctrl}, {15'd0, c});
                check("rs1", {27'd0, ex_rs1}, {27'd0, m_instr[19:15]});
                check("rs2", {27'd0, ex_rs2}, {27'd0, m_instr[24:20]});
                check("rd", {27'd0, ex_rd}, {27'd0, m_instr[11:7]});
                check("imm", ex_imm, is_legal(m_instr[6:0]) ? ref_imm(m_instr) : ex_imm);
                check("illegal", {31'd0, ex_illegal}, {31'd0, !is_legal(m_instr[6:0])});
            end
        end
        m_acc = if_valid && er;
        if (rst) begin
            m_known  = 1'b1;
            m_valid  = 1'b0;
            m_bubble = 1'b0;
        end else if (m_known) begin
            if (flush) m_valid = 1'b0;
            else if (m_acc) begin
                m_valid  = 1'b1;
                m_bubble = 1'b0;
                m_pc     = if_pc;
                m_instr  = if_instr;
            end else if (hz && ex_ready) m_bubble = 1'b1;
            else if (ex_ready) m_valid = 1'b0;
        end
    end

    task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        rst = r; if_valid = v; if_pc = pc; if_instr = ins; ex_ready = rdy; flush = fl;
    endtask

    localparam logic [31:0] ADDI  = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADD   = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] LW5   = 32'h00012283;  // lw x5,0(x2)
    localparam logic [31:0] ADD6  = 32'h00728333;  // add x6,x5,x7
    localparam logic [31:0] LW0   = 32'h00012003;  // lw x0,0(x2)
    localparam logic [31:0] ADD00 = 32'h00000333;  // add x6,x0,x0
    localparam logic [31:0] BEQ   = 32'hFE000EE3;  // beq x0,x0,-4

    initial begin
        logic        have;
        logic [31:0] cur_i, cur_pc, next_pc;

        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_pc", ex_pc, 32'd0);
        check("rst_ex_instr", ex_instr, NOP);
        check("rst_ex_ctrl", {15'd0, ex_ctrl}, 32'd0);
        check("rst_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, 32'd0);
        check("rst_imm_ill", ex_imm | {31'd0, ex_illegal}, 32'd0);

        drive(0, 1, 32'h100, ADDI, 1, 0);
        @(negedge clk);
        check("addi_accept", {31'd0, if_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h104, ADD, 0, 0);
            @(negedge clk);
            check("addi_valid", {31'd0, ex_valid}, 32'd1);
            check("addi_pc", ex_pc, 32'h100);
            check("addi_imm", ex_imm, 32'd5);
            check("addi_rd", {27'd0, ex_rd}, 32'd1);
            check("addi_lr", {31'd0, ex_ctrl.load_regfile}, 32'd1);
            check("addi_aluop", {29'd0, ex_ctrl.aluop}, {29'd0, alu_add});
            check("stall_if_ready", {31'd0, if_ready}, 32'd0);
        end
        drive(0, 1, 32'h104, ADD, 1, 0);
        @(negedge clk);
        check("release_if_ready", {31'd0, if_ready}, 32'd1);
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        check("next_pc", ex_pc, 32'h104);
        check("next_instr", ex_instr, ADD);

        drive(0, 1, 32'h200, LW5, 1, 0);
        drive(0, 1, 32'h204, ADD6, 1, 0);
        @(negedge clk);
        check("lw_pc", ex_pc, 32'h200);
        check("lw_hazard_ready", {31'd0, if_ready}, 32'd0);
        drive(0, 1, 32'h204, ADD6, 1, 0);
        @(negedge clk);
        check("bubble_valid", {31'd0, ex_valid}, 32'd1);
        check("bubble_ctrl_lit", {15'd0, ex_ctrl}, 32'd0);
        check("bubble_instr_lit", ex_instr, NOP);
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        check("use_pc", ex_pc, 32'h204);
        check("use_instr", ex_instr, ADD6);

        drive(0, 1, 32'h300, LW0, 1, 0);
        drive(0, 1, 32'h304, ADD00, 1, 0);
        @(negedge clk);
        check("x0_no_hazard", {31'd0, if_ready}, 32'd1);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        check("x0_next_pc", ex_pc, 32'h304);

        drive(0, 1, 32'h400, ADDI, 0, 1);
        @(negedge clk);
        check("flush_if_ready", {31'd0, if_ready}, 32'd0);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_after_ready", {31'd0, if_ready}, 32'd1);

        drive(0, 1, 32'h500, 32'hFFFFFFFF, 1, 0);
        drive(0, 1, 32'h504, BEQ, 1, 0);
        @(negedge clk);
        check("ill_flag", {31'd0, ex_illegal}, 32'd1);
        check("ill_enables", {28'd0, ex_ctrl.load_regfile, ex_ctrl.mem_read,
                              ex_ctrl.mem_write, ex_ctrl.br_sel}, 32'd0);
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        check("beq_imm", ex_imm, 32'hFFFFFFFC);
        check("beq_br_sel", {31'd0, ex_ctrl.br_sel}, 32'd1);

        drive(0, 1, 32'h600, LW5, 1, 0);
        drive(0, 1, 32'h604, ADD6, 0, 0);
        @(negedge clk);
        check("hz_stall_pc", ex_pc, 32'h600);
        drive(1, 1, 32'h604, ADD6, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        check("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_stall_instr", ex_instr, NOP);

        have = 1'b0;
        cur_i = 32'd0;
        cur_pc = 32'd0;
        next_pc = 32'h1000;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (m_acc) have = 1'b0;
            if (!have && $urandom_range(0, 9) < 7) begin
                have = 1'b1;
                cur_i = rand_instr();
                cur_pc = next_pc;
                next_pc = next_pc + 32'd4;
            end
            if_valid = have;
            if_instr = cur_i;
            if_pc = cur_pc;
            ex_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL take parameter NOP_INSTR, default 32'h00000013, meaning the instruction encoding reported for bubbles and after reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port if_valid, input, 1: fetch presents an instruction.
REQ-005 SHALL have port if_ready, output, 1: the stage accepts the fetch instruction this cycle.
REQ-006 SHALL have ports if_pc and if_instr, input, 32 each: fetch PC and instruction word.
REQ-007 SHALL have ports ex_valid (output, 1) and ex_ready (input, 1): the execute-side handshake.
REQ-008 SHALL have ports ex_pc and ex_instr, output, 32 each: the registered PC and instruction.
REQ-009 SHALL have port ex_ctrl, output, rv32i_control_word: the registered control word.
REQ-010 SHALL have ports ex_rs1, ex_rs2 and ex_rd, output, 5 each; and port ex_imm, output, 32: the sign-extended immediate.
REQ-011 SHALL have port ex_illegal, output, 1: the opcode is not in rv32i_opcode.
REQ-012 SHALL have port flush, input, 1: EX redirect; kill held and incoming instructions.

Function
REQ-013 Transfer rules:
- Input transfer SHALL occur when if_valid && if_ready.
- Output transfer SHALL occur when ex_valid && ex_ready.
REQ-014 The stage SHALL hold one output register set with three states:
- EMPTY: ex_valid=0.
- FULL: ex_valid=1.
- BUBBLE: ex_valid=1, ex_ctrl all-zero, ex_instr=NOP_INSTR.
REQ-015 if_ready SHALL equal !rst && !flush && !hazard && (state==EMPTY || ex_ready).
REQ-016 On input transfer, the next state SHALL be FULL with decoded outputs registered; latency is 1 cycle, instruction to ex_valid.
REQ-017 When FULL and !ex_ready, all outputs SHALL hold stable; no new input is accepted.
REQ-018 hazard SHALL be the conjunction of:
- state==FULL
- ex_ctrl.mem_read
- ex_rd!=0
- if_valid
- if_instr's opcode reads rs1 or rs2 and that source equals ex_rd.
Source reads: op_br/op_store/op_reg read rs1 and rs2; op_jalr/op_load/op_imm read rs1 only.
REQ-019 If hazard && ex_ready, the next state SHALL be BUBBLE; the fetch instruction is held upstream and accepted on the following cycle.
REQ-020 If hazard && !ex_ready, the state SHALL hold FULL.
REQ-021 BUBBLE SHALL hold until ex_ready, then transition to FULL on input transfer, otherwise EMPTY.
REQ-022 flush SHALL force the next state to EMPTY regardless of ex_ready, if_valid or hazard; flush has priority over every other event.
REQ-023 When state is EMPTY and ex_ready=1, the output transfer SHALL be a no-op.
REQ-024 Immediate generation SHALL be sign-extended from instr[31]:
- I: op_jalr, op_load, op_imm
- S: op_store
- B: op_br, bit0=0
- U: op_lui, op_auipc, low 12 bits zero
- J: op_jal, bit0=0
- op_reg: zero
REQ-025 aluop SHALL equal funct3, with these overrides:
- op_reg add with instr[30]=1 → alu_sub.
- sr with instr[30]=1 → alu_sra; otherwise alu_srl.
- slt/sltu → cmpop blt/bltu.
- op_br → cmpop=funct3.
REQ-026 load_regfile SHALL be 1 for lui, auipc, jal, jalr, load, imm and reg, and 0 otherwise; it SHALL be 0 when rd==0.
REQ-027 mem_read SHALL be 1 only for op_load; mem_write SHALL be 1 only for op_store; br_sel SHALL be 1 for op_br, op_jal and op_jalr.
REQ-028 An illegal opcode SHALL:
- set ex_illegal=1;
- zero load_regfile, mem_read, mem_write and br_sel;
- still transfer normally.

Reset
REQ-029 While rst=1 at a clock edge, the next state SHALL be EMPTY.
REQ-030 Reset values SHALL be:
- ex_valid=0, ex_illegal=0
- ex_pc=0, ex_instr=NOP_INSTR
- ex_ctrl all-zero
- ex_rs1=ex_rs2=ex_rd=0, ex_imm=0
REQ-031 if_ready SHALL be 0 during rst.
REQ-032 Reset asserted mid-stall SHALL discard held and bubble state with no output transfer.

Structure
REQ-033 A typedef decode_out_t (ctrl, rs1, rs2, rd, imm, illegal) SHALL be added to rv32i_types.
REQ-034 The existing mux enum packages and alu_ops SHALL be reused unchanged.
REQ-035 NOP_INSTR SHALL be a constant in rv32i_types.
REQ-036 Decoding SHALL be a combinational sub-module, control_decoder (instr → decode_out_t), instantiated once; decode_stage owns the state, handshake and hazard logic.

Verification
REQ-037 Pipelined flow: addi x1,x0,5 (0x00500093) at pc 0x100 with if_valid=1, ex_ready=1 → next cycle ex_valid=1, ex_pc=0x100, ex_imm=5, ex_rd=1, load_regfile=1, aluop=alu_add.
REQ-038 Backpressure: ex_ready=0 for 3 cycles while FULL → outputs stable and if_ready=0 for 3 cycles; the next instruction appears one cycle after ex_ready=1.
REQ-039 Load-use: lw x5,0(x2) then add x6,x5,x7 → one BUBBLE cycle (ex_valid=1, ctrl zero), then the add; zero instructions lost or duplicated.
REQ-040 No false hazard: lw x0 followed by add x6,x0,x0 → no bubble inserted.
REQ-041 Flush during a stall: flush=1 while FULL with !ex_ready → next cycle ex_valid=0; if_ready=1 afterwards.
REQ-042 Illegal/imm: instr 0xFFFFFFFF → ex_illegal=1, all write/branch enables 0; beq with imm=-4 → ex_imm=0xFFFFFFFC.
